// File: rtl/ddr_rx_pkg.sv
// ddr_rx_pkg: shared states, tap width, timing constants and window-centre helper for the delay calibration logic
package ddr_rx_pkg;
  localparam int TAP_W = 9;
  localparam int MIN_SETTLE = 4;
  localparam int DDR_STEP_LATENCY = 2;
  typedef enum logic [3:0] {
    IDLE, VTC_OFF, LOAD0, SETTLE, SAMPLE, STEP, CENTER_LOAD, CENTER_SETTLE, VERIFY, FINISH
  } state_t;
  function automatic logic [TAP_W-1:0] window_centre(input logic [TAP_W-1:0] start, input logic [TAP_W:0] len);
    logic [TAP_W:0] half;
    half = (len - 1'b1) >> 1;
    return start + half[TAP_W-1:0];
  endfunction
endpackage

// File: rtl/idelay_window_tracker.sv
// idelay_window_tracker: tracks the current and widest passing tap runs and the centre of the widest one
module idelay_window_tracker
  import ddr_rx_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             strobe,
  input  logic             pass,
  input  logic [TAP_W-1:0] tap,
  output logic [TAP_W:0]   best_len,
  output logic [TAP_W-1:0] centre
);
  logic [TAP_W:0] run_len, next_len;
  logic [TAP_W-1:0] run_start, best_start, next_start;
  always_comb begin
    next_len = pass ? run_len + 1'b1 : '0;
    next_start = pass && run_len == '0 ? tap : run_start;
  end
  assign centre = window_centre(best_start, best_len);
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      run_len <= '0;
      run_start <= '0;
      best_len <= '0;
      best_start <= '0;
    end else if (strobe) begin
      run_len <= next_len;
      run_start <= next_start;
      if (next_len > best_len) begin
        best_len <= next_len;
        best_start <= next_start;
      end
    end
  end
endmodule

// File: rtl/idelay_tap_align.sv
// idelay_tap_align: sweeps input delay taps against a training pattern and loads the centre of the widest passing window
module idelay_tap_align
  import ddr_rx_pkg::*;
#(
  parameter int               WIDTH         = 1,
  parameter int               MAX_TAP       = 511,
  parameter int               SAMPLE_CYCLES = 64,
  parameter int               SETTLE_CYCLES = 8,
  parameter int               VTC_WAIT      = 16,
  parameter logic [WIDTH-1:0] TRAIN_Q1      = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] TRAIN_Q2      = {WIDTH{1'b0}}
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [WIDTH-1:0]         q1,
  input  logic [WIDTH-1:0]         q2,
  input  logic [WIDTH*TAP_W-1:0]   cnt_value_out,
  output logic                     en,
  output logic                     inc,
  output logic                     load,
  output logic [TAP_W-1:0]         cnt_value_in,
  output logic                     en_vtc,
  output logic                     busy,
  output logic                     done,
  output logic                     locked,
  output logic                     fail,
  output logic [TAP_W-1:0]         center_tap,
  output logic [TAP_W:0]           eye_width
);
  localparam int SETTLE_N = SETTLE_CYCLES < MIN_SETTLE ? MIN_SETTLE : SETTLE_CYCLES;
  state_t state, next;
  logic [15:0] cnt;
  logic [TAP_W-1:0] tap, held, centre;
  logic [TAP_W:0] best_len;
  logic [WIDTH-1:0] rb_tap, rb_ctr;
  logic ok, match, last, tap_ok, ctr_ok;
  int lim;
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    assign rb_tap[i] = cnt_value_out[i*TAP_W +: TAP_W] == tap;
    assign rb_ctr[i] = cnt_value_out[i*TAP_W +: TAP_W] == centre;
  end
  always_comb begin
    match = q1 == TRAIN_Q1 && q2 == TRAIN_Q2;
    tap_ok = &rb_tap;
    ctr_ok = &rb_ctr;
    lim = state == VTC_OFF ? VTC_WAIT : state == SAMPLE ? SAMPLE_CYCLES : SETTLE_N;
    last = cnt == 16'(lim - 1);
  end
  always_comb begin
    next = state;
    case (state)
      IDLE:          if (start) next = VTC_OFF;
      VTC_OFF:       if (last) next = LOAD0;
      LOAD0:         next = SETTLE;
      SETTLE:        if (last) next = tap_ok ? SAMPLE : FINISH;
      SAMPLE:        if (last) next = tap == TAP_W'(MAX_TAP) ? CENTER_LOAD : STEP;
      STEP:          next = SETTLE;
      CENTER_LOAD:   next = best_len == '0 ? FINISH : CENTER_SETTLE;
      CENTER_SETTLE: if (last) next = VERIFY;
      VERIFY:        next = FINISH;
      default:       next = IDLE;
    endcase
  end
  always_comb begin
    en = state == STEP;
    busy = state != IDLE && state != FINISH;
    inc = busy;
    load = state == LOAD0 || (state == CENTER_LOAD && best_len != '0);
    cnt_value_in = state == LOAD0 ? '0 : load ? centre : held;
    en_vtc = state == IDLE || state == FINISH;
    done = state == FINISH;
  end
  idelay_window_tracker u_tracker (
    .clk(clk),
    .rst(rst),
    .clear(state == LOAD0),
    .strobe(state == SAMPLE && last),
    .pass(ok && match),
    .tap(tap),
    .best_len(best_len),
    .centre(centre)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      tap <= '0;
      held <= '0;
      ok <= 1'b1;
      locked <= 1'b0;
      fail <= 1'b0;
      center_tap <= '0;
      eye_width <= '0;
    end else begin
      state <= next;
      cnt <= next != state ? '0 : cnt + 1'b1;
      ok <= state == SAMPLE ? ok && match : 1'b1;
      tap <= state == LOAD0 ? '0 : state == STEP ? tap + 1'b1 : tap;
      held <= cnt_value_in;
      if (state == IDLE && start) begin
        locked <= 1'b0;
        fail <= 1'b0;
      end
      if ((state == SETTLE && last && !tap_ok) || (state == CENTER_LOAD && best_len == '0) || (state == VERIFY && !ctr_ok))
        fail <= 1'b1;
      if (state == VERIFY && ctr_ok) begin
        locked <= 1'b1;
        center_tap <= centre;
        eye_width <= best_len;
      end
    end
  end
endmodule
